dmi_responder: RTL and testbench

//  Core-side DMI target: consumes DMI requests emerging from the JTAG->core CDC
//  (core_dmi_req side), decodes {addr,data,op}, performs a single register-bus

---
 rtl/dmi_responder.sv | 171 +++++++++++++++++
 tb/tb_dmi_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_responder.sv
// Core-side DMI target: one request at a time becomes one register-bus access, answered with {data,resp}.
// Latency: NOP/rsvd respond 1 cycle after accept, RD/WR 1 cycle after ack/timeout; no new request until the response is taken.
module dmi_responder #(
  parameter int ABITS   = 7,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmi_req_valid_i,
  input  logic [ABITS+DW+1:0]   dmi_req_i,
  output logic                  dmi_req_ready_o,
  output logic                  dmi_resp_valid_o,
  output logic [DW+1:0]         dmi_resp_o,
  input  logic                  dmi_resp_ready_i,
  output logic                  reg_req_o,
  output logic                  reg_we_o,
  output logic [ABITS-1:0]      reg_addr_o,
  output logic [DW-1:0]         reg_wdata_o,
  input  logic                  reg_ack_i,
  input  logic [DW-1:0]         reg_rdata_i,
  input  logic                  reg_err_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_RD     = 2'd1;
  localparam logic [1:0] OP_WR     = 2'd2;
  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              reg_req_q, reg_req_nxt;
  logic              reg_we_q, reg_we_nxt;
  logic [ABITS-1:0]  reg_addr_q, reg_addr_nxt;
  logic [DW-1:0]     reg_wdata_q, reg_wdata_nxt;
  logic              resp_valid_q, resp_valid_nxt;
  logic [DW-1:0]     resp_data_q, resp_data_nxt;
  logic [1:0]        resp_code_q, resp_code_nxt;

  logic [ABITS-1:0]  req_addr;
  logic [DW-1:0]     req_data;
  logic [1:0]        req_op;
  logic              accept;
  logic              expired;

  assign req_addr = dmi_req_i[ABITS+DW+1 -: ABITS];
  assign req_data = dmi_req_i[DW+1:2];
  assign req_op   = dmi_req_i[1:0];

  assign dmi_req_ready_o = (state == IDLE);
  assign accept          = dmi_req_valid_i && dmi_req_ready_o;
  assign expired         = (cnt == CNT_LAST);

  // State register; all outputs except ready are registered here too
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      reg_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_code_q  <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      reg_req_q    <= reg_req_nxt;
      reg_we_q     <= reg_we_nxt;
      reg_addr_q   <= reg_addr_nxt;
      reg_wdata_q  <= reg_wdata_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_data_q  <= resp_data_nxt;
      resp_code_q  <= resp_code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_op == OP_RD || req_op == OP_WR) state_nxt = ACCESS;
          else                                    state_nxt = RESP;
        end
      end
      ACCESS: begin
        if (reg_ack_i || expired) state_nxt = RESP;
      end
      RESP: begin
        if (dmi_resp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt        = cnt;
    reg_req_nxt    = reg_req_q;
    reg_we_nxt     = reg_we_q;
    reg_addr_nxt   = reg_addr_q;
    reg_wdata_nxt  = reg_wdata_q;
    resp_valid_nxt = resp_valid_q;
    resp_data_nxt  = resp_data_q;
    resp_code_nxt  = resp_code_q;
    case (state)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_NOP: begin
              resp_valid_nxt = 1'b1;
              resp_data_nxt  = '0;
              resp_code_nxt  = RESP_OK;
            end
            OP_RD, OP_WR: begin
              reg_req_nxt   = 1'b1;
              reg_we_nxt    = (req_op == OP_WR);
              reg_addr_nxt  = req_addr;
              reg_wdata_nxt = req_data;
              cnt_nxt       = '0;
            end
            default: begin
              resp_valid_nxt = 1'b1;
              resp_data_nxt  = '0;
              resp_code_nxt  = RESP_FAIL;
            end
          endcase
        end
      end
      ACCESS: begin
        // An ack arriving on the expiry cycle still completes the access
        if (reg_ack_i) begin
          reg_req_nxt    = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = (!reg_we_q && !reg_err_i) ? reg_rdata_i : '0;
          resp_code_nxt  = reg_err_i ? RESP_FAIL : RESP_OK;
        end else if (expired) begin
          reg_req_nxt    = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = '0;
          resp_code_nxt  = RESP_FAIL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        if (dmi_resp_ready_i) resp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign reg_req_o        = reg_req_q;
  assign reg_we_o         = reg_we_q;
  assign reg_addr_o       = reg_addr_q;
  assign reg_wdata_o      = reg_wdata_q;
  assign dmi_resp_valid_o = resp_valid_q;
  assign dmi_resp_o       = {resp_data_q, resp_code_q};

endmodule

// File: tb/tb_dmi_responder.sv
// Directed bench for dmi_responder: default-timeout instance plus a TIMEOUT=4 instance sharing stimulus.
module tb_dmi_responder;

  localparam int ABITS = 7;
  localparam int DW    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [ABITS+DW+1:0] req = '0;
  logic              resp_ready = 1'b0;
  logic              ack = 1'b0;
  logic [DW-1:0]     rdata = '0;
  logic              err = 1'b0;

  logic              req_ready, resp_valid, reg_req, reg_we;
  logic [DW+1:0]     resp;
  logic [ABITS-1:0]  reg_addr;
  logic [DW-1:0]     reg_wdata;

  logic              t_req_ready, t_resp_valid, t_reg_req, t_reg_we;
  logic [DW+1:0]     t_resp;
  logic [ABITS-1:0]  t_reg_addr;
  logic [DW-1:0]     t_reg_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmi_responder #(.ABITS(ABITS), .DW(DW), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst),
    .dmi_req_valid_i(req_valid), .dmi_req_i(req), .dmi_req_ready_o(req_ready),
    .dmi_resp_valid_o(resp_valid), .dmi_resp_o(resp), .dmi_resp_ready_i(resp_ready),
    .reg_req_o(reg_req), .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
    .reg_ack_i(ack), .reg_rdata_i(rdata), .reg_err_i(err)
  );

  dmi_responder #(.ABITS(ABITS), .DW(DW), .TIMEOUT(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .dmi_req_valid_i(req_valid), .dmi_req_i(req), .dmi_req_ready_o(t_req_ready),
    .dmi_resp_valid_o(t_resp_valid), .dmi_resp_o(t_resp), .dmi_resp_ready_i(resp_ready),
    .reg_req_o(t_reg_req), .reg_we_o(t_reg_we), .reg_addr_o(t_reg_addr), .reg_wdata_o(t_reg_wdata),
    .reg_ack_i(ack), .reg_rdata_i(rdata), .reg_err_i(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [ABITS+DW+1:0] mk_req(input logic [ABITS-1:0] a,
                                                  input logic [DW-1:0] d,
                                                  input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_reg_req", 64'(reg_req), 64'd0);
    check("rst_reg_we", 64'(reg_we), 64'd0);
    check("rst_reg_addr", 64'(reg_addr), 64'd0);
    check("rst_reg_wdata", 64'(reg_wdata), 64'd0);
    rst = 1'b0;

    // RD with one-cycle ack
    req_valid = 1'b1;
    req = mk_req(7'h11, 32'h0, 2'd1);
    step();
    req_valid = 1'b0;
    check("rd_reg_req", 64'(reg_req), 64'd1);
    check("rd_reg_we", 64'(reg_we), 64'd0);
    check("rd_reg_addr", 64'(reg_addr), 64'h11);
    check("rd_req_ready_busy", 64'(req_ready), 64'd0);
    check("rd_no_resp_yet", 64'(resp_valid), 64'd0);
    ack = 1'b1;
    rdata = 32'hDEADBEEF;
    step();
    ack = 1'b0;
    check("rd_reg_req_drop", 64'(reg_req), 64'd0);
    check("rd_resp_valid", 64'(resp_valid), 64'd1);
    check("rd_resp", 64'(resp), {30'd0, 32'hDEADBEEF, 2'd0});
    handshake("rd");

    // WR with ack after 5 cycles
    req_valid = 1'b1;
    req = mk_req(7'h10, 32'h00000001, 2'd2);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("wr_req_c%0d", i), 64'(reg_req), 64'd1);
      check($sformatf("wr_wdata_c%0d", i), 64'(reg_wdata), 64'd1);
      check($sformatf("wr_we_c%0d", i), 64'(reg_we), 64'd1);
      if (i == 5) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    check("wr_resp_valid", 64'(resp_valid), 64'd1);
    check("wr_resp", 64'(resp), 64'd0);
    handshake("wr");

    // RD with error
    req_valid = 1'b1;
    req = mk_req(7'h11, 32'h0, 2'd1);
    step();
    req_valid = 1'b0;
    ack = 1'b1;
    err = 1'b1;
    rdata = 32'h12345678;
    step();
    ack = 1'b0;
    err = 1'b0;
    check("rderr_resp", 64'(resp), 64'd2);
    handshake("rderr");

    // NOP and reserved op answer next cycle without a register access
    req_valid = 1'b1;
    req = mk_req(7'h05, 32'h0000FFFF, 2'd0);
    step();
    req_valid = 1'b0;
    check("nop_reg_req", 64'(reg_req), 64'd0);
    check("nop_resp_valid", 64'(resp_valid), 64'd1);
    check("nop_resp", 64'(resp), 64'd0);
    handshake("nop");
    req_valid = 1'b1;
    req = mk_req(7'h05, 32'h0000AAAA, 2'd3);
    step();
    req_valid = 1'b0;
    check("rsvd_reg_req", 64'(reg_req), 64'd0);
    check("rsvd_resp_valid", 64'(resp_valid), 64'd1);
    check("rsvd_resp", 64'(resp), 64'd2);
    handshake("rsvd");

    // Response backpressure with a second request waiting
    req_valid = 1'b1;
    req = mk_req(7'h22, 32'h0, 2'd1);
    step();
    req = mk_req(7'h33, 32'h00000055, 2'd2);
    ack = 1'b1;
    rdata = 32'hCAFEF00D;
    step();
    ack = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("bp_valid_c%0d", i), 64'(resp_valid), 64'd1);
      check($sformatf("bp_resp_c%0d", i), 64'(resp), {30'd0, 32'hCAFEF00D, 2'd0});
      check($sformatf("bp_ready_c%0d", i), 64'(req_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_valid_drop", 64'(resp_valid), 64'd0);
    check("bp_ready_back", 64'(req_ready), 64'd1);
    check("bp_not_yet_accepted", 64'(reg_req), 64'd0);
    step();
    req_valid = 1'b0;
    check("bp_next_reg_req", 64'(reg_req), 64'd1);
    check("bp_next_we", 64'(reg_we), 64'd1);
    check("bp_next_addr", 64'(reg_addr), 64'h33);
    check("bp_next_wdata", 64'(reg_wdata), 64'h55);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("bp_next_resp", 64'(resp), 64'd0);
    handshake("bp_next");

    // Reset mid-ACCESS
    req_valid = 1'b1;
    req = mk_req(7'h44, 32'h0, 2'd1);
    step();
    req_valid = 1'b0;
    check("ra_reg_req", 64'(reg_req), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ra_reg_req_drop", 64'(reg_req), 64'd0);
    check("ra_reg_addr", 64'(reg_addr), 64'd0);
    check("ra_resp_valid", 64'(resp_valid), 64'd0);
    check("ra_req_ready", 64'(req_ready), 64'd1);

    // Reset mid-RESP
    req_valid = 1'b1;
    req = mk_req(7'h01, 32'h0, 2'd3);
    step();
    req_valid = 1'b0;
    check("rr_resp_valid", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_resp_valid_drop", 64'(resp_valid), 64'd0);
    check("rr_resp_zero", 64'(resp), 64'd0);
    check("rr_req_ready", 64'(req_ready), 64'd1);

    // Stray ack in IDLE is ignored
    ack = 1'b1;
    rdata = 32'h00000999;
    step();
    step();
    ack = 1'b0;
    check("stray_resp_valid", 64'(resp_valid), 64'd0);
    check("stray_reg_req", 64'(reg_req), 64'd0);
    check("stray_req_ready", 64'(req_ready), 64'd1);

    // Normal RD after resets
    req_valid = 1'b1;
    req = mk_req(7'h12, 32'h0, 2'd1);
    step();
    req_valid = 1'b0;
    check("post_reg_addr", 64'(reg_addr), 64'h12);
    ack = 1'b1;
    rdata = 32'h0BADF00D;
    step();
    ack = 1'b0;
    check("post_resp", 64'(resp), {30'd0, 32'h0BADF00D, 2'd0});
    handshake("post");

    // TIMEOUT=4 instance: timeout, then ack on the expiry cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t_rst_ready", 64'(t_req_ready), 64'd1);
    req_valid = 1'b1;
    req = mk_req(7'h21, 32'h0, 2'd1);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_req_c%0d", i), 64'(t_reg_req), 64'd1);
      check($sformatf("to_novalid_c%0d", i), 64'(t_resp_valid), 64'd0);
      step();
    end
    check("to_req_drop", 64'(t_reg_req), 64'd0);
    check("to_resp_valid", 64'(t_resp_valid), 64'd1);
    check("to_resp", 64'(t_resp), 64'd2);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("to_valid_drop", 64'(t_resp_valid), 64'd0);
    req_valid = 1'b1;
    req = mk_req(7'h21, 32'h0, 2'd1);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("toack_req_c%0d", i), 64'(t_reg_req), 64'd1);
      if (i == 4) begin
        ack = 1'b1;
        rdata = 32'h13572468;
      end
      step();
    end
    ack = 1'b0;
    check("toack_resp_valid", 64'(t_resp_valid), 64'd1);
    check("toack_resp", 64'(t_resp), {30'd0, 32'h13572468, 2'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
